// File: rtl/clk_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : clk_gen_pkg
//  Description : Shared definitions for the clock-generation chain
//                (divide_by_2, clk_div_n and their benches).
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_gen_pkg;

  // Smallest divisor that still yields a real divided clock.
  localparam int MIN_DIV = 2;

  // Nominal divisor width used across the chain.
  localparam int DIV_WIDTH = 8;

  typedef logic [DIV_WIDTH-1:0] div_t;

endpackage
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : clk_div_ctrl
//  Description : Divisor load/pending/apply control for clk_div_n. Holds the
//                pending divisor and issues the ack/err status pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
  import clk_gen_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  input  logic             wrap,      // counter is on its last cycle of the period
  output logic [WIDTH-1:0] n_pend,
  output logic             apply,     // swap n_pend into the active divisor on this edge
  output logic             div_ack,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(MIN_DIV);

  logic pend;
  logic val_ok;
  logic load_ok;

  assign val_ok  = (div_val >= MIN_VAL);
  assign load_ok = div_load && val_ok;

  // Pending state is sampled before this edge, so a load landing on the wrap
  // edge itself waits for the following wrap.
  assign apply = wrap && pend;

  // Pending divisor: a valid load always wins (last value wins, and a load
  // coinciding with an apply re-arms pend for the next boundary).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend   <= 1'b0;
      n_pend <= RST_DIV;
    end else if (load_ok) begin
      pend   <= 1'b1;
      n_pend <= div_val;
    end else if (apply) begin
      pend   <= 1'b0;
    end
  end

  // Status pulses: ack in the first cycle of the new period, err one cycle
  // after an out-of-range load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      div_ack <= apply;
      div_err <= div_load && !val_ok;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : clk_div_n
//  Description : Programmable integer clock divider, 50 % duty for even and
//                odd divisors, glitch-free divisor change at period boundary,
//                plus a one-cycle tick aligned with each clk_out rise.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_n
  import clk_gen_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick
);

  // A misconfigured default below the minimum is clamped so the counter
  // always has at least two states.
  localparam int               EFF_DEFAULT = (DEFAULT_DIV < MIN_DIV) ? MIN_DIV : DEFAULT_DIV;
  localparam logic [WIDTH-1:0] RST_DIV     = WIDTH'(EFF_DEFAULT);
  localparam logic [WIDTH-1:0] RST_CNT     = WIDTH'(EFF_DEFAULT - 1);

  logic [WIDTH-1:0] n_cur;
  logic [WIDTH-1:0] n_pend;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] high_len;
  logic             wrap;
  logic             apply;
  logic             p;
  logic             q;

  // Counter runs 0 .. n_cur-1; the wrap compare keeps it from ever passing
  // n_cur-1, so the maximum divisor cannot overflow the counter.
  assign wrap     = (cnt == (n_cur - 1'b1));
  assign cnt_next = wrap ? '0 : (cnt + 1'b1);

  // High-phase length H = ceil(n_cur/2); fits in WIDTH for n_cur <= 2^WIDTH-1.
  assign high_len = (n_cur >> 1) + {{(WIDTH-1){1'b0}}, n_cur[0]};

  clk_div_ctrl #(
    .WIDTH   (WIDTH),
    .RST_DIV (RST_DIV)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .div_val  (div_val),
    .div_load (div_load),
    .wrap     (wrap),
    .n_pend   (n_pend),
    .apply    (apply),
    .div_ack  (div_ack),
    .div_err  (div_err)
  );

  // Period counter and active divisor; a new divisor takes over exactly when
  // the counter restarts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= RST_CNT;
      n_cur <= RST_DIV;
    end else begin
      cnt <= cnt_next;
      if (apply) begin
        n_cur <= n_pend;
      end
    end
  end

  // Posedge phase flop and tick. At a wrap cnt_next is 0, which is below H
  // for any divisor, so p rises on every period start regardless of whether
  // n_cur is changing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p    <= 1'b0;
      tick <= 1'b0;
    end else begin
      p    <= (cnt_next < high_len);
      tick <= wrap;
    end
  end

  // Half-cycle delayed copy of p; ANDing it in trims half an input cycle off
  // the high phase so odd divisors come out at exactly N/2.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      q <= p;
    end
  end

  // n_cur only changes on an edge where p was low, so switching between the
  // odd and even forms cannot produce a runt pulse.
  assign clk_out = n_cur[0] ? (p & q) : p;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_n
//  Description : Self-checking bench for clk_div_n with a behavioural model
//                built from period/phase arithmetic in nanoseconds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_n;
  import clk_gen_pkg::*;

  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 4;
  localparam int TCLK        = 10;

  logic             clk      = 1'b1;
  logic             reset    = 1'b1;
  logic [WIDTH-1:0] div_val  = '0;
  logic             div_load = 1'b0;
  logic             div_ack;
  logic             div_err;
  logic             clk_out;
  logic             tick;

  int      checks   = 0;
  int      failures = 0;
  bit      en       = 1'b0;
  realtime t_load   = 0;

  clk_div_n #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .div_val  (div_val),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_err  (div_err),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #(TCLK/2) clk = ~clk;

  // ---------------- reference model ----------------
  // phase = input cycles elapsed since the current period started.
  typedef struct {
    int n;
    int phase;
    int pend_n;
    bit pend;
    bit tick;
    bit ack;
    bit err;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.n = DEFAULT_DIV; r.phase = DEFAULT_DIV - 1; r.pend_n = 0;
    r.pend = 1'b0; r.tick = 1'b0; r.ack = 1'b0; r.err = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t s, input bit load, input int val);
    model_t r;
    r = s;
    r.tick = 1'b0; r.ack = 1'b0; r.err = 1'b0;
    if (r.phase == r.n - 1) begin
      r.phase = 0;
      r.tick  = 1'b1;
      if (r.pend) begin
        r.n = r.pend_n; r.pend = 1'b0; r.ack = 1'b1;
      end
    end else begin
      r.phase = r.phase + 1;
    end
    if (load) begin
      if (val >= MIN_DIV) begin
        r.pend = 1'b1; r.pend_n = val;
      end else begin
        r.err = 1'b1;
      end
    end
    return r;
  endfunction

  // 50 % duty in time: even N is high for the first 5N ns of the period,
  // odd N is high for 5N ns starting half a cycle into the period.
  function automatic bit exp_clk(input model_t s, input bit half);
    int t;
    t = s.phase * TCLK + (half ? TCLK/2 : 0);
    if (s.n % 2 == 1) return (t >= TCLK/2) && (t < TCLK/2 + s.n * TCLK/2);
    return t < s.n * TCLK/2;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= model_reset();
    else       m <= model_step(m, div_load, int'(div_val));
  end

  // Cycle-by-cycle comparison against the model, both clock phases.
  always @(posedge clk) begin
    #1;
    if (en) begin
      checks++;
      if ({tick, div_ack, div_err, clk_out} !== {m.tick, m.ack, m.err, exp_clk(m, 1'b0)}) begin
        failures++;
        $display("FAIL model_rise t=%0t: got tick/ack/err/clk=%b%b%b%b expected %b%b%b%b",
                 $time, tick, div_ack, div_err, clk_out, m.tick, m.ack, m.err, exp_clk(m, 1'b0));
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (en) begin
      checks++;
      if ({tick, div_ack, div_err, clk_out} !== {m.tick, m.ack, m.err, exp_clk(m, 1'b1)}) begin
        failures++;
        $display("FAIL model_fall t=%0t: got tick/ack/err/clk=%b%b%b%b expected %b%b%b%b",
                 $time, tick, div_ack, div_err, clk_out, m.tick, m.ack, m.err, exp_clk(m, 1'b1));
      end
    end
  end

  // ---------------- measurement recorders ----------------
  realtime rise_t = 0, fall_t = 0, high_ns = 0, low_ns = 0, tick_t = 0, tick_per = 0;
  int      ack_cnt = 0, err_cnt = 0;

  always @(posedge clk_out) begin
    low_ns <= $realtime - fall_t;
    rise_t <= $realtime;
  end

  always @(negedge clk_out) begin
    high_ns <= $realtime - rise_t;
    fall_t  <= $realtime;
  end

  always @(negedge clk) begin
    if (tick) begin
      tick_per <= $realtime - tick_t;
      tick_t   <= $realtime;
    end
    if (div_ack) ack_cnt <= ack_cnt + 1;
    if (div_err) err_cnt <= err_cnt + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input int v);
    @(negedge clk);
    div_val  = WIDTH'(v);
    div_load = 1'b1;
    t_load   = $realtime;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic wait_ack(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (div_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tick(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    checks++;
    if ({clk_out, tick, div_ack, div_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0000", {clk_out, tick, div_ack, div_err});
    end
    @(posedge clk);
    en = 1'b1;
    #3;
    checks++;
    if ({clk_out, tick, div_ack, div_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs_clocked: got %b expected 0000", {clk_out, tick, div_ack, div_err});
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (tick !== 1'b1) begin
      failures++; $display("FAIL first_tick: got %b expected 1", tick);
    end
    checks++;
    if (clk_out !== 1'b1) begin
      failures++; $display("FAIL first_clk_out: got %b expected 1", clk_out);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (int'(high_ns) != 20 || int'(low_ns) != 20 || int'(tick_per) != 40) begin
      failures++;
      $display("FAIL reset_period: got high=%0d low=%0d tick=%0d expected 20/20/40",
               int'(high_ns), int'(low_ns), int'(tick_per));
    end
  endtask

  task automatic test_mid_period();
    bit ok;
    int lat;
    wait_tick(10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mid_tick_wait: got timeout expected tick"); end
    @(posedge clk);
    load(6);
    wait_ack(10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mid_ack_wait: got timeout expected ack"); end
    lat = int'(($realtime - t_load) / TCLK);
    checks++;
    if (lat != 3) begin failures++; $display("FAIL mid_ack_latency: got %0d expected 3", lat); end
    checks++;
    if (int'(high_ns) != 20 || int'(low_ns) != 20) begin
      failures++;
      $display("FAIL mid_last_old_period: got high=%0d low=%0d expected 20/20", int'(high_ns), int'(low_ns));
    end
    repeat (14) @(negedge clk);
    checks++;
    if (int'(high_ns) != 30 || int'(low_ns) != 30 || int'(tick_per) != 60) begin
      failures++;
      $display("FAIL mid_new_period: got high=%0d low=%0d tick=%0d expected 30/30/60",
               int'(high_ns), int'(low_ns), int'(tick_per));
    end
  endtask

  task automatic test_odd();
    bit ok;
    int lat;
    load(5);
    wait_ack(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL odd_ack_wait: got timeout expected ack"); end
    lat = int'(($realtime - t_load) / TCLK);
    checks++;
    if (lat < 1 || lat > 6) begin failures++; $display("FAIL odd_ack_latency: got %0d expected 1..6", lat); end
    repeat (12) @(negedge clk);
    checks++;
    if (int'(high_ns) != 25 || int'(low_ns) != 25 || int'(tick_per) != 50) begin
      failures++;
      $display("FAIL odd_period: got high=%0d low=%0d tick=%0d expected 25/25/50",
               int'(high_ns), int'(low_ns), int'(tick_per));
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int a0, e0;
    wait_tick(10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_tick_wait: got timeout expected tick"); end
    a0 = ack_cnt; e0 = err_cnt;
    @(negedge clk); div_val = WIDTH'(7); div_load = 1'b1;
    @(negedge clk); div_val = WIDTH'(3);
    @(negedge clk); div_load = 1'b0;
    wait_ack(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_ack_wait: got timeout expected ack"); end
    repeat (10) @(negedge clk);
    checks++;
    if (ack_cnt - a0 != 1) begin failures++; $display("FAIL b2b_ack_count: got %0d expected 1", ack_cnt - a0); end
    checks++;
    if (err_cnt != e0) begin failures++; $display("FAIL b2b_err_count: got %0d expected 0", err_cnt - e0); end
    checks++;
    if (int'(high_ns) != 15 || int'(low_ns) != 15 || int'(tick_per) != 30) begin
      failures++;
      $display("FAIL b2b_period: got high=%0d low=%0d tick=%0d expected 15/15/30",
               int'(high_ns), int'(low_ns), int'(tick_per));
    end
  endtask

  task automatic test_invalid();
    bit ok;
    int a0, e0;
    int bad_vals[2];
    bad_vals[0] = 1; bad_vals[1] = 0;
    load(4);
    wait_ack(10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL inv_ack_wait: got timeout expected ack"); end
    repeat (8) @(negedge clk);
    a0 = ack_cnt; e0 = err_cnt;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      div_val = WIDTH'(bad_vals[i]); div_load = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (div_err !== 1'b1) begin
        failures++; $display("FAIL inv_err_pulse val=%0d: got %b expected 1", bad_vals[i], div_err);
      end
      @(negedge clk);
      div_load = 1'b0;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (err_cnt - e0 != 2) begin failures++; $display("FAIL inv_err_count: got %0d expected 2", err_cnt - e0); end
    checks++;
    if (ack_cnt != a0) begin failures++; $display("FAIL inv_no_ack: got %0d expected 0", ack_cnt - a0); end
    checks++;
    if (int'(tick_per) != 40) begin failures++; $display("FAIL inv_period: got %0d expected 40", int'(tick_per)); end
  endtask

  task automatic test_max();
    bit ok;
    load(255);
    wait_ack(10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL max_ack_wait: got timeout expected ack"); end
    repeat (2 * 255 + 10) @(negedge clk);
    checks++;
    if (int'(high_ns) != 1275 || int'(low_ns) != 1275 || int'(tick_per) != 2550) begin
      failures++;
      $display("FAIL max_period: got high=%0d low=%0d tick=%0d expected 1275/1275/2550",
               int'(high_ns), int'(low_ns), int'(tick_per));
    end
    load(4);
    wait_ack(260, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL max_restore_ack: got timeout expected ack"); end
  endtask

  task automatic test_random();
    int bad, e0, v;
    bad = 0;
    e0  = err_cnt;
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        v = int'($urandom_range(0, 9));
        div_val  = WIDTH'(v);
        div_load = 1'b1;
        if (v < MIN_DIV) bad++;
      end else begin
        div_load = 1'b0;
      end
    end
    @(negedge clk);
    div_load = 1'b0;
    repeat (25) @(negedge clk);
    checks++;
    if (err_cnt - e0 != bad) begin
      failures++; $display("FAIL rand_err_count: got %0d expected %0d", err_cnt - e0, bad);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int a0;
    load(5);
    wait_ack(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rmid_ack_wait: got timeout expected ack"); end
    wait_tick(10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rmid_tick_wait: got timeout expected tick"); end
    @(negedge clk);
    div_val = WIDTH'(7); div_load = 1'b1;
    @(posedge clk);
    #2;
    div_load = 1'b0;
    checks++;
    if (clk_out !== 1'b1) begin failures++; $display("FAIL rmid_high_phase: got %b expected 1", clk_out); end
    reset = 1'b1;
    #1;
    checks++;
    if ({clk_out, tick, div_ack, div_err} !== 4'b0000) begin
      failures++;
      $display("FAIL rmid_async_clear: got %b expected 0000", {clk_out, tick, div_ack, div_err});
    end
    a0 = ack_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (int'(high_ns) != 20 || int'(low_ns) != 20 || int'(tick_per) != 40) begin
      failures++;
      $display("FAIL rmid_default_period: got high=%0d low=%0d tick=%0d expected 20/20/40",
               int'(high_ns), int'(low_ns), int'(tick_per));
    end
    checks++;
    if (ack_cnt != a0) begin failures++; $display("FAIL rmid_pending_lost: got %0d acks expected 0", ack_cnt - a0); end
  endtask

  initial begin
    test_reset();
    test_mid_period();
    test_odd();
    test_back_to_back();
    test_invalid();
    test_max();
    test_random();
    test_reset_mid();
    @(negedge clk);
    en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
`default_nettype wire
